// File: rtl/isp_dram_sched.sv
// isp_dram_sched: grants ISP picture load/writeback requests and runs one
// full-picture AXI4 INCR burst per grant, streaming beats to/from the core.
// Ports: rd_*/wr_* request/ack/done to core, core_w* write beat stream,
// busy status, AXI4 master (AW/W/B/AR/R) towards the picture DRAM.
module isp_dram_sched #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int unsigned PIC_BYTES = 3072,
  parameter int unsigned BURST_LEN = 192
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rd_req,
  input  logic         wr_req,
  input  logic [3:0]   rd_pic_no,
  input  logic [3:0]   wr_pic_no,
  output logic         rd_ack,
  output logic         wr_ack,
  output logic         rd_valid,
  output logic [127:0] rd_data,
  output logic [7:0]   rd_idx,
  input  logic         core_wvalid,
  input  logic [127:0] core_wdata,
  output logic         core_wready,
  output logic         rd_done,
  output logic         wr_done,
  output logic         busy,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [127:0] wdata,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [127:0] rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  localparam logic [31:0] PIC_B = 32'(PIC_BYTES);
  localparam logic [7:0]  LAST  = 8'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        rd_done_q, rd_done_d;
  logic        wr_done_q, wr_done_d;

  // Response IDs/status are not used: termination is by rlast/bvalid.
  logic unused_inputs;
  assign unused_inputs = ^{bid, bresp, rid, rresp};

  function automatic logic [31:0] pic_addr(input logic [3:0] pic);
    return BASE_ADDR + ({28'd0, pic} * PIC_B);
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rd_done_d = 1'b0;
    wr_done_d = 1'b0;
    rd_ack    = 1'b0;
    wr_ack    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Writeback first so a re-read sees the fresh picture.
        if (wr_req) begin
          wr_ack  = 1'b1;
          addr_d  = pic_addr(wr_pic_no);
          state_d = S_AW;
        end else if (rd_req) begin
          rd_ack  = 1'b1;
          addr_d  = pic_addr(rd_pic_no);
          state_d = S_AR;
        end
      end
      S_AR: begin
        if (arready) begin
          cnt_d   = '0;
          state_d = S_R;
        end
      end
      S_R: begin
        if (rvalid) begin
          cnt_d = cnt_q + 8'd1;
          if (rlast) begin
            rd_done_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_AW: begin
        if (awready) begin
          cnt_d   = '0;
          state_d = S_W;
        end
      end
      S_W: begin
        if (core_wvalid && wready) begin
          if (cnt_q == LAST) begin
            state_d = S_B;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_B: begin
        if (bvalid) begin
          wr_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign rd_done     = rd_done_q;
  assign wr_done     = wr_done_q;

  assign arid        = 4'd0;
  assign arlen       = LAST;
  assign arsize      = 3'b100;
  assign arburst     = 2'b01;
  assign araddr      = addr_q;
  assign arvalid     = (state_q == S_AR);

  assign rready      = (state_q == S_R);
  assign rd_valid    = (state_q == S_R) && rvalid;
  assign rd_data     = rdata;
  assign rd_idx      = cnt_q;

  assign awid        = 4'd0;
  assign awlen       = LAST;
  assign awsize      = 3'b100;
  assign awburst     = 2'b01;
  assign awaddr      = addr_q;
  assign awvalid     = (state_q == S_AW);

  // W channel is a combinational pass-through, gated to the W state.
  assign wvalid      = (state_q == S_W) && core_wvalid;
  assign wdata       = core_wdata;
  assign core_wready = (state_q == S_W) && wready;
  assign wlast       = (state_q == S_W) && (cnt_q == LAST);

  assign bready      = (state_q == S_B);

endmodule

// File: tb/tb_isp_dram_sched.sv
// tb_isp_dram_sched: drives isp_dram_sched with a scripted AXI slave,
// comparing against address/beat expectations computed in the bench.
module tb_isp_dram_sched;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int PICB = 3072;
  localparam int NB   = 192;

  logic clk = 1'b0;
  logic rst_n;
  logic rd_req, wr_req;
  logic [3:0] rd_pic_no, wr_pic_no;
  logic rd_ack, wr_ack, rd_valid;
  logic [127:0] rd_data;
  logic [7:0] rd_idx;
  logic core_wvalid;
  logic [127:0] core_wdata;
  logic core_wready, rd_done, wr_done, busy;
  logic [3:0] awid, arid, bid, rid;
  logic [31:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready;
  logic bvalid, bready, arvalid, arready;
  logic [127:0] wdata, rdata;
  logic rlast, rvalid, rready;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  isp_dram_sched dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .wr_req(wr_req),
    .rd_pic_no(rd_pic_no), .wr_pic_no(wr_pic_no),
    .rd_ack(rd_ack), .wr_ack(wr_ack),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_idx(rd_idx),
    .core_wvalid(core_wvalid), .core_wdata(core_wdata),
    .core_wready(core_wready),
    .rd_done(rd_done), .wr_done(wr_done), .busy(busy),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    bit          wr;
    int          pic;
    logic [31:0] addr;
    int          dly;
    int          gap;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [31:0] model_addr(input int pic);
    return BASE + 32'(pic) * 32'(PICB);
  endfunction

  function automatic logic [127:0] beat_pat(input int pic, input int i);
    return {32'(pic), 32'(i), 32'hC0DE_0000 + 32'(i), ~32'(i)};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_slave();
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    arready = 0; rvalid = 0; rlast = 0; rdata = '0;
    rresp = 0; rid = 0; core_wvalid = 0; core_wdata = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"},
        128'({arvalid, awvalid, rready, bready, wvalid, wlast,
              rd_valid, core_wready, rd_ack, wr_ack,
              rd_done, wr_done, busy}), '0);
    chk({tag, "_addr"}, 128'({araddr, awaddr}), '0);
    chk({tag, "_idx"}, 128'(rd_idx), '0);
  endtask

  task automatic wait_ack(input bit wr, output bit ok);
    int n = 0;
    #1;
    while (!(wr ? wr_ack : rd_ack) && n < 4000) begin
      tick();
      #1;
      n++;
    end
    ok = (n < 4000);
    chk(wr ? "wr_ack_seen" : "rd_ack_seen", 128'(ok), 128'(1));
  endtask

  task automatic do_read(input int pic, input logic [31:0] exp_addr,
                         input int ar_dly, input int gap,
                         input int abort_at, input bit pre_acked);
    bit ok;
    int i, n;
    logic [127:0] d;
    if (!pre_acked) begin
      rd_req = 1; rd_pic_no = 4'(pic);
      wait_ack(0, ok);
      if (!ok) begin rd_req = 0; return; end
      chk("rd_ack_excl", 128'(wr_ack), 0);
    end
    tick();
    rd_req = 0; rd_pic_no = 4'($urandom);
    for (int k = 0; k < ar_dly; k++) begin
      #1;
      chk("arvalid_hold", 128'(arvalid), 1);
      chk("araddr_hold", 128'(araddr), 128'(exp_addr));
      chk("rready_pre", 128'(rready), 0);
      tick();
    end
    arready = 1;
    #1;
    chk("arvalid", 128'(arvalid), 1);
    chk("araddr", 128'(araddr), 128'(exp_addr));
    chk("arlen", 128'({arid, arlen, arsize, arburst}),
        128'({4'd0, 8'd191, 3'b100, 2'b01}));
    tick();
    arready = 0;
    i = 0; n = 0;
    while (i < NB && n < 5000) begin
      if (abort_at >= 0 && i == abort_at) begin
        rvalid = 1;
        #1;
        rst_n = 0;
        #1;
        chk_all_zero("rst_mid_read");
        clr_slave();
        tick(); tick();
        rst_n = 1;
        #1;
        chk_all_zero("rst_release");
        return;
      end
      rvalid = ($urandom_range(99) >= gap);
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      rdata = d;
      rlast = rvalid && (i == NB - 1);
      rid = 4'($urandom); rresp = 2'($urandom);
      #1;
      chk("rready", 128'(rready), 1);
      chk("rd_valid", 128'(rd_valid), 128'(rvalid));
      chk("busy_rd", 128'({busy, rd_done}), 128'(2'b10));
      if (rvalid) begin
        chk("rd_data", rd_data, d);
        chk("rd_idx", 128'(rd_idx), 128'(i));
        i++;
      end
      n++;
      tick();
    end
    chk("rd_beats", 128'(i), 128'(NB));
    rvalid = 0; rlast = 0;
    #1;
    chk("rd_done", 128'(rd_done), 1);
    chk("idle_after_rd", 128'({busy, rready}), 0);
    tick();
    #1;
    chk("rd_done_pulse", 128'(rd_done), 0);
  endtask

  task automatic do_write(input int pic, input logic [31:0] exp_addr,
                          input int aw_dly, input int gap,
                          input int stall, input int b_dly,
                          input bit rd_pend);
    bit ok;
    int i, n;
    wr_req = 1; wr_pic_no = 4'(pic);
    wait_ack(1, ok);
    if (!ok) begin wr_req = 0; return; end
    chk("rd_ack_loses", 128'(rd_ack), 0);
    tick();
    wr_req = 0; wr_pic_no = 4'($urandom);
    core_wvalid = 1; core_wdata = '1;
    for (int k = 0; k < aw_dly; k++) begin
      #1;
      chk("awvalid_hold", 128'(awvalid), 1);
      chk("awaddr_hold", 128'(awaddr), 128'(exp_addr));
      chk("w_gated_aw", 128'({wvalid, core_wready}), 0);
      if (rd_pend) chk("rd_wait_aw", 128'(rd_ack), 0);
      tick();
    end
    awready = 1;
    #1;
    chk("awvalid", 128'(awvalid), 1);
    chk("awaddr", 128'(awaddr), 128'(exp_addr));
    chk("awlen", 128'({awid, awlen, awsize, awburst}),
        128'({4'd0, 8'd191, 3'b100, 2'b01}));
    tick();
    awready = 0;
    i = 0; n = 0;
    while (i < NB && n < 5000) begin
      core_wvalid = ($urandom_range(99) >= gap);
      wready = ($urandom_range(99) >= stall);
      core_wdata = beat_pat(pic, i);
      #1;
      chk("wvalid", 128'(wvalid), 128'(core_wvalid));
      chk("core_wready", 128'(core_wready), 128'(wready));
      chk("wlast", 128'(wlast), 128'(i == NB - 1));
      chk("bready_w", 128'(bready), 0);
      if (rd_pend) chk("rd_wait_w", 128'(rd_ack), 0);
      if (core_wvalid && wready) begin
        chk("wdata", wdata, beat_pat(pic, i));
        i++;
      end
      n++;
      tick();
    end
    chk("w_beats", 128'(i), 128'(NB));
    core_wvalid = 1; wready = 1;
    for (int k = 0; k < b_dly; k++) begin
      #1;
      chk("bready_hold", 128'(bready), 1);
      chk("w_gated_b", 128'({wvalid, wlast, core_wready}), 0);
      if (rd_pend) chk("rd_wait_b", 128'(rd_ack), 0);
      tick();
    end
    core_wvalid = 0; wready = 0;
    bvalid = 1; bresp = 2'($urandom); bid = 4'($urandom);
    #1;
    chk("bready", 128'(bready), 1);
    tick();
    bvalid = 0;
    #1;
    chk("wr_done", 128'(wr_done), 1);
    chk("idle_after_wr", 128'(busy), 0);
    if (rd_pend) begin
      chk("rd_ack_in_done", 128'(rd_ack), 1);
    end else begin
      tick();
      #1;
      chk("wr_done_pulse", 128'(wr_done), 0);
    end
  endtask

  initial begin
    tbl[0] = '{0, 0,  32'h0001_0000, 0, 30};
    tbl[1] = '{0, 15, 32'h0001_B400, 2, 40};
    tbl[2] = '{1, 3,  32'h0001_2400, 1, 30};
    tbl[3] = '{1, 15, 32'h0001_B400, 0, 0};
    tbl[4] = '{0, 7,  32'h0001_5400, 1, 0};
    tbl[5] = '{1, 0,  32'h0001_0000, 3, 50};

    rst_n = 0;
    rd_req = 0; wr_req = 0; rd_pic_no = 0; wr_pic_no = 0;
    clr_slave();
    tick(); tick();
    #1;
    chk_all_zero("reset");
    rst_n = 1;
    tick();

    // Reset in the middle of a read, then a clean read of pic 2.
    do_read(5, model_addr(5), 1, 20, 51, 0);
    tick();
    do_read(2, 32'h0001_1800, 0, 20, -1, 0);

    // Slave holds off arready for 5 cycles.
    do_read(4, 32'h0001_3000, 5, 30, -1, 0);

    // Simultaneous requests: write first, read acked in wr_done cycle.
    rd_req = 1; rd_pic_no = 4'd1;
    do_write(3, 32'h0001_2400, 1, 30, 30, 3, 1);
    do_read(1, 32'h0001_0C00, 0, 20, -1, 1);

    // Back-to-back reads with rvalid gaps.
    do_read(0, 32'h0001_0000, 0, 40, -1, 0);
    do_read(15, 32'h0001_B400, 0, 40, -1, 0);

    for (int t = 0; t < 6; t++) begin
      if (tbl[t].wr)
        do_write(tbl[t].pic, tbl[t].addr, tbl[t].dly, tbl[t].gap,
                 tbl[t].gap, tbl[t].dly, 0);
      else
        do_read(tbl[t].pic, tbl[t].addr, tbl[t].dly, tbl[t].gap, -1, 0);
    end

    for (int r = 0; r < 6; r++) begin
      int pic;
      pic = int'($urandom_range(15));
      if ($urandom_range(1) == 1)
        do_write(pic, model_addr(pic), int'($urandom_range(3)),
                 int'($urandom_range(50)), int'($urandom_range(50)),
                 int'($urandom_range(3)), 0);
      else
        do_read(pic, model_addr(pic), int'($urandom_range(3)),
                int'($urandom_range(50)), -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
